// File: rtl/demultiplexer_buffered_pkg.sv
// Shared constants for the buffered 1-to-2 demultiplexer: per-channel FIFO
// geometry and the channel index encoding used by sel.
package demultiplexer_buffered_pkg;

    localparam int FIFO_DEPTH = 2;
    localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W      = PTR_W + 1;
    localparam int NUM_CH     = 2;

    typedef enum logic {
        CH0 = 1'b0,
        CH1 = 1'b1
    } ch_e;

endpackage

// File: rtl/demultiplexer_buffered_if.sv
// Stream bundle for the demultiplexer: one valid/ready input with sel, two
// valid/ready output channels and the per-channel accepted-word counters.
interface demultiplexer_buffered_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             sel;
    logic             in_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [CNT_W-1:0] count0;
    logic [CNT_W-1:0] count1;

    // master drives the input stream and consumes the outputs
    modport master (
        output in_data, in_valid, sel, out0_ready, out1_ready,
        input  in_ready, out0_data, out0_valid, out1_data, out1_valid, count0, count1
    );

    modport slave (
        input  in_data, in_valid, sel, out0_ready, out1_ready,
        output in_ready, out0_data, out0_valid, out1_data, out1_valid, count0, count1
    );
endinterface

// File: rtl/demultiplexer_buffered_demux_channel_fifo.sv
// One output channel: a 2-entry FIFO with wrapping 1-bit pointers plus a
// counter of words pushed into it.
module demux_channel_fifo
    import demultiplexer_buffered_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             valid,
    output logic [CNT_W-1:0] count
);
    logic [FIFO_DEPTH-1:0][WIDTH-1:0] mem;
    logic [PTR_W-1:0]                 wr_ptr, rd_ptr;
    logic [OCC_W-1:0]                 occ;
    logic                             push_en, pop_en;

    assign full      = (occ == OCC_W'(FIFO_DEPTH));
    assign valid     = (occ != '0);
    assign head_data = mem[rd_ptr];

    // Guard locally too so a misbehaving caller cannot corrupt occupancy.
    assign push_en = push & ~full;
    assign pop_en  = pop & valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
                count       <= count + CNT_W'(1);
            end
            if (pop_en)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_en, pop_en})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end
endmodule

// File: rtl/demultiplexer_buffered.sv
// Buffered 1-to-2 demultiplexer: steers each accepted input word into the
// FIFO of the channel named by sel; channels drain independently.
module demultiplexer_buffered
    import demultiplexer_buffered_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    demultiplexer_buffered_if.slave bus
);
    logic [NUM_CH-1:0]            push, pop, full, valid, ready;
    logic [NUM_CH-1:0][WIDTH-1:0] head;
    logic [NUM_CH-1:0][CNT_W-1:0] count;
    logic                         in_ready;

    // Depends only on the addressed FIFO's fullness, never on out*_ready.
    assign in_ready     = ~full[bus.sel];
    assign bus.in_ready = in_ready;
    assign ready        = {bus.out1_ready, bus.out0_ready};

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign push[c] = bus.in_valid & in_ready & (bus.sel == 1'(c));
        assign pop[c]  = valid[c] & ready[c];

        demux_channel_fifo #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push[c]),
            .push_data (bus.in_data),
            .full      (full[c]),
            .pop       (pop[c]),
            .head_data (head[c]),
            .valid     (valid[c]),
            .count     (count[c])
        );
    end

    assign bus.out0_data  = head[CH0];
    assign bus.out0_valid = valid[CH0];
    assign bus.count0     = count[CH0];
    assign bus.out1_data  = head[CH1];
    assign bus.out1_valid = valid[CH1];
    assign bus.count1     = count[CH1];
endmodule
